// File: rtl/dav_pkg.sv
// dav_pkg: shared scanner state encoding, default sizes and address-width helper
package dav_pkg;
   localparam int DEF_SAMPLES = 32;
   localparam int DEF_MAG_W   = 16;

   function automatic int addr_w(input int n);
      return $clog2(n);
   endfunction

   localparam int DEF_AW = addr_w(DEF_SAMPLES);

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;
endpackage

// File: rtl/peak_tracker.sv
// peak_tracker: running maximum of returned magnitudes plus the published result registers
module peak_tracker #(
   parameter int AW    = 5,
   parameter int MAG_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             init,
   input  logic             valid,
   input  logic             load,
   input  logic [MAG_W-1:0] data,
   input  logic [AW-1:0]    idx,
   output logic [MAG_W-1:0] peak_mag,
   output logic [AW-1:0]    peak_idx
);
   logic [MAG_W-1:0] max_mag, nxt_mag;
   logic [AW-1:0]    max_idx, nxt_idx;
   logic             take;

   // first sample seeds the max; later ones win only when strictly greater, so ties keep the lowest bin
   always_comb begin
      take    = init | (data > max_mag);
      nxt_mag = take ? data : max_mag;
      nxt_idx = take ? idx : max_idx;
   end

   // the running max follows every returned sample; results capture the final max including the last sample
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         max_mag  <= '0;
         max_idx  <= '0;
         peak_mag <= '0;
         peak_idx <= '0;
      end else begin
         if (valid) begin
            max_mag <= nxt_mag;
            max_idx <= nxt_idx;
         end
         if (load) begin
            peak_mag <= nxt_mag;
            peak_idx <= nxt_idx;
         end
      end
   end
endmodule

// File: rtl/spectrum_peak_scanner.sv
// spectrum_peak_scanner: scans each completed ping-pong spectrum frame for its dominant bin
module spectrum_peak_scanner
   import dav_pkg::*;
#(
   parameter int SAMPLES = DEF_SAMPLES,
   parameter int MAG_W   = DEF_MAG_W,
   parameter bit SKIP_DC = 1'b1,
   localparam int AW     = addr_w(SAMPLES)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             frame_ready,
   input  logic             frame_ram,
   output logic             rd_en,
   output logic             rd_sel,
   output logic [AW-1:0]    rd_addr,
   input  logic [MAG_W-1:0] rd_data,
   output logic [AW-1:0]    index_holder,
   output logic             whichRAM,
   output logic [MAG_W-1:0] peak_mag,
   output logic             done,
   output logic             result_pulse,
   output logic             busy,
   output logic             overrun
);
   localparam logic [AW-1:0] START = AW'(SKIP_DC);
   localparam logic [AW-1:0] LAST  = AW'(SAMPLES - 1);

   state_t        state, nxt;
   logic          pend, pend_ram;
   logic          v_d;
   logic [AW-1:0] a_d;
   logic          accept, launch;

   assign accept = (state != SCAN);
   assign launch = accept & (frame_ready | pend);

   // state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= nxt;
   end

   // IDLE and DRAIN both launch a scan when work is available; SCAN ends after issuing the last bin
   always_comb begin
      nxt = (state == SCAN) ? ((rd_addr == LAST) ? DRAIN : SCAN)
                            : ((frame_ready | pend) ? SCAN : IDLE);
   end

   // Moore outputs decoded from the registered state
   always_comb begin
      rd_en        = (state == SCAN);
      busy         = (state != IDLE);
      result_pulse = (state == DRAIN);
   end

   // address counter, RAM select, pending slot and result bookkeeping
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_sel   <= 1'b0;
         rd_addr  <= '0;
         pend     <= 1'b0;
         pend_ram <= 1'b0;
         overrun  <= 1'b0;
         v_d      <= 1'b0;
         a_d      <= '0;
         whichRAM <= 1'b0;
         done     <= 1'b0;
      end else begin
         v_d <= rd_en;
         a_d <= rd_addr;
         if (launch) begin
            rd_sel  <= pend ? pend_ram : frame_ram;
            rd_addr <= START;
         end else if (rd_en) begin
            rd_addr <= rd_addr + 1'b1;
         end
         // a queued frame is older than one arriving now, so it is served first and the new one waits
         if (accept) begin
            pend <= pend & frame_ready;
         end else if (frame_ready) begin
            pend    <= 1'b1;
            overrun <= overrun | pend;
         end
         if (frame_ready) pend_ram <= frame_ram;
         if (result_pulse) begin
            whichRAM <= rd_sel;
            done     <= 1'b1;
         end
      end
   end

   peak_tracker #(.AW(AW), .MAG_W(MAG_W)) u_trk (
      .clk      (clk),
      .reset_n  (reset_n),
      .init     (v_d & (a_d == START)),
      .valid    (v_d),
      .load     (result_pulse),
      .data     (rd_data),
      .idx      (a_d),
      .peak_mag (peak_mag),
      .peak_idx (index_holder)
   );
endmodule

// File: doc/spectrum_peak_scanner.md
# spectrum_peak_scanner

Sequencer that scans one completed frame of spectrum magnitudes from the ping-pong spectrum RAMs and produces the dominant-bin index, the RAM it came from and a sticky result-valid flag. It sits between the spectrum write side, which announces each filled RAM, and the color stage, which consumes `index_holder`, `whichRAM` and `done`. One read per cycle, one scan per frame; a frame that arrives mid-scan is queued so the next scan starts with no idle gap.

## Interface
- `SAMPLES`, 32, bins per frame; power of two, ≥ 4
- `MAG_W`, 16, unsigned magnitude width
- `SKIP_DC`, 1, 1 = bin 0 excluded from the scan
- `clk`  in  1  sole clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `frame_ready`  in  1  one-cycle pulse: RAM `frame_ram` holds a complete frame
- `frame_ram`  in  1  RAM select accompanying `frame_ready`
- `rd_en`  out  1  read strobe to spectrum RAMs
- `rd_sel`  out  1  RAM being read
- `rd_addr`  out  $clog2(SAMPLES)  bin address
- `rd_data`  in  MAG_W  magnitude, valid exactly 1 cycle after `rd_en`
- `index_holder`  out  $clog2(SAMPLES)  winning bin of last completed scan
- `whichRAM`  out  1  RAM of last completed scan
- `peak_mag`  out  MAG_W  magnitude of the winning bin
- `done`  out  1  sticky: at least one scan has completed since reset
- `result_pulse`  out  1  one cycle when new results load
- `busy`  out  1  scan in progress
- `overrun`  out  1  sticky: a queued frame was replaced before use

## Operation
- States: IDLE, SCAN, DRAIN.
- IDLE: on `frame_ready` (or pending flag set) → SCAN; latch `rd_sel` ← `frame_ram` (or pending RAM); clear pending.
- SCAN: `rd_en`=1; `rd_addr` runs START..SAMPLES-1, one per cycle, START = `SKIP_DC` ? 1 : 0. Issuing SAMPLES-1 → DRAIN.
- DRAIN: `rd_en`=0; last returned sample compared; result registers load; `result_pulse`=1. Next state: SCAN if pending or `frame_ready` this cycle, else IDLE.
- Compare: running max initialised with the first returned sample and its address; later sample replaces it only if strictly greater. Ties → lowest index. All-zero frame → index START.
- Results (`index_holder`, `whichRAM`, `peak_mag`) update only in the DRAIN cycle, atomically; stable at all other times.
- `done` set at first DRAIN, cleared only by reset.
- `frame_ready` while not IDLE-accepting: stored in single-entry pending slot (RAM latched). If the slot is already full, it is overwritten with the newer RAM and `overrun` set.
- `frame_ready` in the DRAIN cycle: starts the next SCAN directly, not queued.
- `busy` = state ≠ IDLE.

## Timing
- Reset values: `rd_en`, `rd_sel`, `rd_addr`, `index_holder`, `whichRAM`, `peak_mag`, `done`, `result_pulse`, `busy`, `overrun`, pending = 0; state IDLE.
- `frame_ready` sampled at edge 0 → first `rd_en` in cycle 1 → last address in cycle N = SAMPLES-START → DRAIN in cycle N+1 → new results and `done` visible from cycle N+2.
- SAMPLES=32, SKIP_DC=1: frame_ready → results at +33 cycles; back-to-back frame period 32 cycles.
- All outputs registered; no combinational input-to-output path.
- Reset asserted mid-scan: scan abandoned immediately, pending discarded, all outputs to reset values; after release, block idles until the next `frame_ready`.

## Structure
- Shared package `dav_pkg`: state enum (IDLE/SCAN/DRAIN), default `SAMPLES`, `MAG_W`, and the address-width constant.
- One sub-module, `peak_tracker`: running max/index register with init, compare and load controls; the FSM, address counter and pending slot stay in the top.

## Test plan
- Frame RAM0, magnitudes = bin index → `index_holder`=31, `peak_mag`=31, `whichRAM`=0, `done` rises 33 cycles after `frame_ready`.
- Frame RAM1, bins 5 and 12 both 0x0400, rest 0x0010 → `index_holder`=5, `whichRAM`=1.
- Bin 0 = 0xFFFF, rest 0 with SKIP_DC=1 → `index_holder`=1, `peak_mag`=0; with SKIP_DC=0 → `index_holder`=0.
- `frame_ready` RAM1 at scan cycle 10, then RAM0 at cycle 20 → `overrun`=1, next scan reads RAM0 starting the cycle after DRAIN, no idle cycle.
- `frame_ready` coincident with DRAIN → `rd_en` high the following cycle, `result_pulse` exactly once per scan.
- `reset_n` low at scan cycle 15 → all outputs 0 at once, `done`=0; no `rd_en` until the next `frame_ready`.
